// File: rtl/mul_add_pipe.sv
// mul_add_pipe: pipelined shift-add multiply-accumulate, product = quotient*divisor + remainder.
// Rebuilds the dividend from a restoring-divider result, one quotient bit per stage, MSB first.
// Also flags operand sets that cannot be a legal division result (rem_err).
module mul_add_pipe #(
   parameter int N = 5,  // quotient width, also the number of pipeline stages
   parameter int M = 3   // divisor and remainder width
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             EN,
   input  logic             in_valid,
   input  logic [N-1:0]     quotient,
   input  logic [M-1:0]     divisor,
   input  logic [M-1:0]     remainder,
   output logic             out_valid,
   output logic [N+M-1:0]   product,
   output logic             rem_err
);

   // The maximum result is 2^N*(2^M-1), which is below 2^(N+M).
   // Every sum fits in W bits, so no carry-out or saturation handling is needed.
   localparam int W = N + M;

   // Per-stage registers. r_q holds the quotient bits that are still unconsumed,
   // left-aligned, so the next bit to use is always the MSB.
   logic          r_v   [N];
   logic [W-1:0]  r_acc [N];
   logic [N-1:0]  r_q   [N];
   logic [M-1:0]  r_d   [N];
   logic [M-1:0]  r_r   [N];
   logic          r_err [N];

   logic [W-1:0]  w_sum [N];   // next accumulator value for each stage
   logic [M-1:0]  w_rem_last;  // remainder that the final stage adds in
   logic          w_err0;

   // The last stage takes its remainder from the stage before it. With N=1 the
   // single stage is also the last one, so it takes the remainder straight from the input.
   generate
      if (N == 1) begin : g_rem_direct
         assign w_rem_last = remainder;
      end else begin : g_rem_piped
         assign w_rem_last = r_r[N-2];
      end
   endgenerate

   // A legal division result needs a nonzero divisor and a remainder below the divisor.
   assign w_err0 = (divisor == '0) | (remainder >= divisor);

   // Next accumulator for each stage: shift the previous partial product left by one,
   // then add the divisor if the current quotient bit is set. The last stage also adds the remainder.
   always_comb begin
      for (int k = 0; k < N; k++) begin
         w_sum[k] = '0;
      end
      w_sum[0] = quotient[N-1] ? W'(divisor) : '0;
      for (int k = 1; k < N; k++) begin
         w_sum[k] = (r_acc[k-1] << 1) + (r_q[k-1][N-1] ? W'(r_d[k-1]) : '0);
      end
      w_sum[N-1] = w_sum[N-1] + W'(w_rem_last);
   end

   // Pipeline registers. A synchronous RESET flushes every stage, and RESET wins over EN.
   // While EN=0 all stages hold their values.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         // NOTE: the datapath is cleared along with the valids because product must read 0 after reset.
         for (int k = 0; k < N; k++) begin
            r_v[k]   <= 1'b0;
            r_acc[k] <= '0;
            r_q[k]   <= '0;
            r_d[k]   <= '0;
            r_r[k]   <= '0;
            r_err[k] <= 1'b0;
         end
      end else if (EN) begin
         // NOTE: non-blocking assignments let every stage read its predecessor's pre-edge value.
         r_v[0]   <= in_valid;
         r_acc[0] <= w_sum[0];
         r_q[0]   <= quotient << 1;
         r_d[0]   <= divisor;
         r_r[0]   <= remainder;
         r_err[0] <= w_err0;
         for (int k = 1; k < N; k++) begin
            r_v[k]   <= r_v[k-1];
            r_acc[k] <= w_sum[k];
            r_q[k]   <= r_q[k-1] << 1;
            r_d[k]   <= r_d[k-1];
            r_r[k]   <= r_r[k-1];
            r_err[k] <= r_err[k-1];
         end
      end
   end

   assign out_valid = r_v[N-1];
   assign product   = r_acc[N-1];
   assign rem_err   = r_err[N-1];

endmodule

// File: tb/tb_mul_add_pipe.sv
// Scoreboard bench for mul_add_pipe.
// The driver pushes the expected result together with the EN-edge at which it must appear.
// The monitor pops and compares each time the output stage advances with out_valid=1.
module tb_mul_add_pipe;

   localparam int N = 5;
   localparam int M = 3;
   localparam int W = N + M;

   logic          CLK = 1'b0;
   logic          RESET;
   logic          EN;
   logic          in_valid;
   logic [N-1:0]  quotient;
   logic [M-1:0]  divisor;
   logic [M-1:0]  remainder;
   logic          out_valid;
   logic [W-1:0]  product;
   logic          rem_err;

   int checks   = 0;
   int errors   = 0;
   int en_edges = 0;   // number of edges so far with EN=1 and RESET=0

   typedef struct {
      logic [W-1:0] p;
      logic         e;
      int           edge_no;
   } exp_t;

   exp_t sb[$];

   always #5 CLK = ~CLK;

   mul_add_pipe #(.N(N), .M(M)) dut (
      .CLK       (CLK),
      .RESET     (RESET),
      .EN        (EN),
      .in_valid  (in_valid),
      .quotient  (quotient),
      .divisor   (divisor),
      .remainder (remainder),
      .out_valid (out_valid),
      .product   (product),
      .rem_err   (rem_err)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, req);
      end
   endtask

   // Apply one cycle of stimulus. An accepted operand set is loaded at edge en_edges+1,
   // so its result must appear after edge en_edges+N.
   task automatic drive(input logic en, input logic v, input logic [N-1:0] q,
                        input logic [M-1:0] d, input logic [M-1:0] r,
                        input logic [W-1:0] p, input logic e);
      @(negedge CLK);
      EN = en; in_valid = v; quotient = q; divisor = d; remainder = r;
      if (en && v) sb.push_back(exp_t'{p, e, en_edges + N});
   endtask

   task automatic idle(input int n);
      repeat (n) drive(1'b1, 1'b0, '0, '0, '0, '0, 1'b0);
   endtask

   task automatic do_reset(input string tag);
      @(negedge CLK);
      RESET = 1'b1; in_valid = 1'b0;
      sb.delete();
      @(negedge CLK);
      RESET = 1'b0;
      check({tag, " out_valid"}, 64'(out_valid), 64'd0);
      check({tag, " product"},   64'(product),   64'd0);
      check({tag, " rem_err"},   64'(rem_err),   64'd0);
   endtask

   // Monitor: on each advancing edge, pop the expected entry if out_valid=1.
   // On a frozen edge, check that the outputs did not move.
   initial begin
      logic adv, rst;
      logic pv, pe;
      logic [W-1:0] pp;
      exp_t x;
      pv = 1'b0; pe = 1'b0; pp = '0;
      forever begin
         @(posedge CLK);
         rst = RESET;
         adv = EN && !RESET;
         if (adv) en_edges++;
         #1;
         if (!adv && !rst) begin
            check("hold out_valid", 64'(out_valid), 64'(pv));
            check("hold product",   64'(product),   64'(pp));
            check("hold rem_err",   64'(rem_err),   64'(pe));
         end
         if (adv && out_valid) begin
            if (sb.size() == 0) begin
               check("unexpected out_valid", 64'(out_valid), 64'd0);
            end else begin
               x = sb.pop_front();
               check("product", 64'(product), 64'(x.p));
               check("rem_err", 64'(rem_err), 64'(x.e));
               check("latency edge", 64'(en_edges), 64'(x.edge_no));
            end
         end
         pv = out_valid; pp = product; pe = rem_err;
      end
   end

   initial begin
      logic          en, v, e;
      logic [N-1:0]  q;
      logic [M-1:0]  d, r;
      logic [W-1:0]  p;
      int            guard;

      RESET = 1'b1; EN = 1'b0; in_valid = 1'b0;
      quotient = '0; divisor = '0; remainder = '0;
      repeat (2) @(negedge CLK);
      RESET = 1'b0;
      check("reset out_valid", 64'(out_valid), 64'd0);
      check("reset product",   64'(product),   64'd0);
      check("reset rem_err",   64'(rem_err),   64'd0);

      // Single operation.
      drive(1'b1, 1'b1, 5'd22, 3'd3, 3'd2, 8'd68, 1'b0);
      idle(N + 2);

      // Back-to-back stream.
      drive(1'b1, 1'b1, 5'd31, 3'd7, 3'd6, 8'd223, 1'b0);
      drive(1'b1, 1'b1, 5'd0,  3'd5, 3'd4, 8'd4,   1'b0);
      drive(1'b1, 1'b1, 5'd1,  3'd1, 3'd0, 8'd1,   1'b0);
      idle(N + 2);

      // Illegal division results, with a bubble between them.
      drive(1'b1, 1'b1, 5'd10, 3'd0, 3'd3, 8'd3,  1'b1);
      drive(1'b1, 1'b0, 5'd0,  3'd0, 3'd0, 8'd0,  1'b0);
      drive(1'b1, 1'b1, 5'd10, 3'd7, 3'd7, 8'd77, 1'b1);
      idle(N + 2);

      // Freeze for 3 cycles in the middle of an operation. The valid input presented
      // while EN=0 must be ignored.
      drive(1'b1, 1'b1, 5'd22, 3'd3, 3'd2, 8'd68, 1'b0);
      drive(1'b1, 1'b0, 5'd0,  3'd0, 3'd0, 8'd0,  1'b0);
      drive(1'b0, 1'b1, 5'd9,  3'd5, 3'd1, 8'd0,  1'b0);
      drive(1'b0, 1'b0, 5'd0,  3'd0, 3'd0, 8'd0,  1'b0);
      drive(1'b0, 1'b1, 5'd3,  3'd3, 3'd0, 8'd0,  1'b0);
      idle(N + 2);

      // Freeze while a result sits on the output.
      drive(1'b1, 1'b1, 5'd7, 3'd6, 3'd5, 8'd47, 1'b0);
      idle(N - 1);
      drive(1'b0, 1'b0, 5'd0, 3'd0, 3'd0, 8'd0, 1'b0);
      drive(1'b0, 1'b0, 5'd0, 3'd0, 3'd0, 8'd0, 1'b0);
      idle(N + 2);

      // Reset mid-flight: the three sets in the pipeline must never come out.
      drive(1'b1, 1'b1, 5'd5,  3'd3, 3'd1, 8'd16,  1'b0);
      drive(1'b1, 1'b1, 5'd17, 3'd4, 3'd2, 8'd70,  1'b0);
      drive(1'b1, 1'b1, 5'd30, 3'd7, 3'd0, 8'd210, 1'b0);
      do_reset("flush");
      idle(N + 2);

      // Random stream, with the reference model computed here in the bench.
      for (int i = 0; i < 1000; i++) begin
         en = ($urandom_range(0, 3) != 0);
         v  = ($urandom_range(0, 2) != 0);
         q  = N'($urandom);
         d  = M'($urandom);
         r  = M'($urandom);
         p  = W'(q) * W'(d) + W'(r);
         e  = (d == '0) || (r >= d);
         drive(en, v, q, d, r, p, e);
      end

      // Drain the pipeline, with a bound on the number of cycles.
      guard = 0;
      while (sb.size() != 0 && guard < 4 * N) begin
         idle(1);
         guard++;
      end
      check("drain pending", 64'(sb.size()), 64'd0);
      idle(2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mul_add_pipe.md
# mul_add_pipe

Pipelined shift-add multiply-accumulate that computes `quotient*divisor + remainder`. It is the reconstruction direction of the team's restoring divider: it takes a divider result (quotient, divisor, remainder) and rebuilds the dividend. It sits behind the divider chain as a self-check and recombination stage, with one pipeline stage per quotient bit, MSB first. It accepts one operand set per cycle.

## Interface

Parameters:
- `N`, default 5: quotient width; also the number of pipeline stages.
- `M`, default 3: divisor and remainder width.

Ports:
- `CLK`  in  1  rising-edge clock.
- `RESET`  in  1  reset: RESET, synchronous, active-high.
- `EN`  in  1  global advance enable; 0 freezes the whole pipeline.
- `in_valid`  in  1  operand set on the inputs is valid; sampled only when EN=1.
- `quotient`  in  N  quotient operand.
- `divisor`  in  M  divisor operand.
- `remainder`  in  M  remainder operand.
- `out_valid`  out  1  `product`/`rem_err` are valid.
- `product`  out  N+M  `quotient*divisor + remainder`.
- `rem_err`  out  1  the operand set was not a legal division result: `divisor==0` or `remainder>=divisor`.

## Operation

- Pipeline stages are 0..N-1. Each stage register holds:
  - `v`: valid.
  - `acc`: N+M bits.
  - remaining quotient bits.
  - `divisor` and `remainder` copies.
  - `err`.
- Stage 0 load, on EN=1:
  - `v0 = in_valid`.
  - `acc0 = quotient[N-1] ? divisor : 0`, zero-extended.
  - `err0 = (divisor==0) | (remainder>=divisor)`.
- Stage k (1..N-1), on EN=1:
  - `acc_k = (acc_{k-1} << 1) + (q[N-1-k] ? divisor : 0)`.
  - Stage N-1 additionally adds the zero-extended `remainder`.
  - `v`, `err`, `divisor`, `remainder` are copied forward.
- `product`, `rem_err` and `out_valid` are the stage N-1 registers.
- Width rule: all arithmetic is N+M bits. The maximum result is `(2^N-1)(2^M-1)+(2^M-1) = 2^N(2^M-1) < 2^(N+M)`, so no overflow can occur and no saturation logic is needed.
- `rem_err` does not alter `product`; the arithmetic is computed regardless.
- Stages with v=0 still shift data. Their contents are don't-care, but `out_valid=0` marks them. The implementation may zero them to save toggling.
- There is no back-pressure. The consumer must accept `product` whenever `out_valid=1` and EN=1.

## Timing

- Reset: on a rising CLK with RESET=1, every stage register clears to 0. After reset, `out_valid=0`, `product=0`, `rem_err=0`.
- RESET has priority over EN.
- Latency: an operand set presented with `in_valid=1` at edge t (EN=1 at every edge) appears with `out_valid=1` after edge t+N-1. That is N register stages; the output is visible in cycle t+N-1.
- Throughput: 1 result per cycle. Back-to-back `in_valid` produces back-to-back `out_valid` with no bubbles.
- EN=0 at an edge:
  - All registers hold, including `out_valid` and `product`.
  - Inputs are ignored.
  - Latency is counted in EN=1 edges only.
- RESET asserted mid-operation flushes every in-flight operand set. No stale `out_valid` is produced after RESET deasserts.
- A bubble (`in_valid=0`) between two valid sets propagates as a one-cycle `out_valid=0` gap.
- N=1 is legal: one stage, which both loads and adds `remainder`.

## Test plan

Defaults N=5, M=3, EN=1 unless stated.

- Single op: q=22, d=3, r=2 → after N edges `out_valid=1`, `product=68`, `rem_err=0`; the following cycle `out_valid=0`.
- Back-to-back stream: (31,7,6), (0,5,4), (1,1,0) on consecutive cycles → outputs 223, 4, 1 on three consecutive cycles, each with `rem_err=0`.
- Error flags:
  - (10,0,3) → `product=3`, `rem_err=1`.
  - (10,7,7) → `product=77`, `rem_err=1`.
- Freeze: feed (22,3,2), then drop EN for 3 cycles after the 2nd stage → all outputs hold during the freeze; 68 appears exactly 3 cycles later than in the unstalled case.
- Reset mid-flight: feed 3 valid sets, assert RESET for 1 cycle after 2 edges → `out_valid=0` and `product=0` the cycle after reset, and no output from the flushed sets ever appears.
- Random scoreboard: 1000 random operand sets with random EN/`in_valid` → `product==q*d+r` and `rem_err` correct, in order.
